// File: rtl/halt_ctrl.sv
// Run/step/halt controller for a 6502: debounced buttons drive the RDY line and a halt-indicator latch.
// Optional breakpoint compare is compiled in with HALT_CTRL_BRK_EN.
module halt_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_run_n,
  input  logic        btn_step_n,
  input  logic        btn_halt_n,
  input  logic        sync,
`ifdef HALT_CTRL_BRK_EN
  input  logic [15:0] addr,
  input  logic [15:0] brk_addr,
  input  logic        brk_arm,
`endif
  output logic        rdy,
  output logic        latch_s_n,
  output logic        latch_r_n,
  output logic [1:0]  state,
  output logic [7:0]  step_count
);

  typedef enum logic [1:0] {
    S_HALT   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP_A = 2'b10,
    S_STEP_B = 2'b11
  } state_e;

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  // Button vectors are ordered {halt, step, run}.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q, sync3_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      armed_q, armed_d;
  logic [2:0]      press_q, press_d;
  logic [2:0][7:0] cnt_q, cnt_d;

  state_e          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic            latch_s_n_q, latch_s_n_d;
  logic            latch_r_n_q, latch_r_n_d;
  logic [7:0]      step_count_q, step_count_d;
  logic            brk_hit;

  assign btn_raw = {btn_halt_n, btn_step_n, btn_run_n};

  // A button only produces events once it has been seen released for a full
  // debounce interval, so a button held through reset stays silent.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]   = deb_q[i];
      armed_d[i] = armed_q[i];
      press_d[i] = 1'b0;
      cnt_d[i]   = 8'd0;
      if (sync2_q[i] != sync3_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = armed_q[i] & ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else if (!armed_q[i] && deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) armed_d[i] = 1'b1;
        else                     cnt_d[i]   = cnt_q[i] + 8'd1;
      end
    end
  end

`ifdef HALT_CTRL_BRK_EN
  assign brk_hit = sync && brk_arm && (addr == brk_addr);
`else
  assign brk_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    step_count_d = step_count_q;
    case (state_q)
      S_HALT: begin
        if (press_q[2])      state_d = S_HALT;
        else if (press_q[0]) state_d = S_RUN;
        else if (press_q[1]) state_d = S_STEP_A;
      end
      S_RUN: begin
        if (press_q[2] || brk_hit) state_d = S_HALT;
      end
      S_STEP_A: begin
        if (press_q[2]) state_d = S_HALT;
        else if (!sync) state_d = S_STEP_B;
      end
      S_STEP_B: begin
        if (press_q[2]) begin
          state_d = S_HALT;
        end else if (sync) begin
          state_d      = S_HALT;
          step_count_d = step_count_q + 8'd1;
        end
      end
      default: state_d = S_HALT;
    endcase
    rdy_d       = (state_d != S_HALT);
    latch_s_n_d = !((state_d == S_HALT) && (state_q != S_HALT));
    latch_r_n_d = !((state_q == S_HALT) && (state_d == S_RUN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 3'b111;
      sync2_q      <= 3'b111;
      sync3_q      <= 3'b111;
      deb_q        <= 3'b111;
      armed_q      <= 3'b000;
      press_q      <= 3'b000;
      cnt_q        <= '0;
      state_q      <= S_HALT;
      rdy_q        <= 1'b0;
      latch_s_n_q  <= 1'b1;
      latch_r_n_q  <= 1'b1;
      step_count_q <= 8'd0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      deb_q        <= deb_d;
      armed_q      <= armed_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      latch_s_n_q  <= latch_s_n_d;
      latch_r_n_q  <= latch_r_n_d;
      step_count_q <= step_count_d;
    end
  end

  assign rdy        = rdy_q;
  assign latch_s_n  = latch_s_n_q;
  assign latch_r_n  = latch_r_n_q;
  assign state      = state_q;
  assign step_count = step_count_q;

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: cycles a button must be stable before the debounced level changes; range 2..255.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 btn_run_n  in  1  raw run pushbutton, active-low, asynchronous to clk.
REQ-005 btn_step_n  in  1  raw single-step pushbutton, active-low, asynchronous to clk.
REQ-006 btn_halt_n  in  1  raw halt pushbutton, active-low, asynchronous to clk.
REQ-007 sync  in  1  6502 SYNC, high during opcode-fetch cycle.
REQ-008 rdy  out  1  6502 RDY; 1 = CPU runs, 0 = CPU stalled.
REQ-009 latch_s_n  out  1  halt-indicator RS latch set, active-low one-cycle pulse.
REQ-010 latch_r_n  out  1  halt-indicator RS latch reset, active-low one-cycle pulse.
REQ-011 state  out  2  current state: 00 HALT, 01 RUN, 10 STEP_A, 11 STEP_B.
REQ-012 step_count  out  8  number of completed single steps.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose counter reloads on any change and updates the debounced level after DEBOUNCE_CYCLES stable cycles.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced level's 1->0 transition; holding a button SHALL produce no further events.
REQ-015 HALT: rdy=0; run event -> RUN; step event -> STEP_A; halt event ignored.
REQ-016 RUN: rdy=1; halt event -> HALT; run and step events ignored.
REQ-017 STEP_A: rdy=1; sync sampled 0 -> STEP_B (current opcode fetch completed).
REQ-018 STEP_B: rdy=1; sync sampled 1 -> HALT, step_count increments by 1 (CPU stops at next opcode fetch).
REQ-019 halt event in STEP_A or STEP_B SHALL go directly to HALT without incrementing step_count.
REQ-020 Simultaneous events: halt beats run beats step.
REQ-021 rdy SHALL be registered, decoded from next state; it changes on the same edge as state.
REQ-022 latch_s_n SHALL be 0 for exactly one cycle on each transition into HALT; latch_r_n SHALL be 0 for exactly one cycle on each HALT->RUN transition; never both 0.
REQ-023 step_count SHALL wrap 255->0.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=HALT, rdy=0, latch_s_n=1, latch_r_n=1, step_count=0, synchronizers and debounced levels to 1 (released), debounce counters to 0.
REQ-025 Reset mid-step or mid-run SHALL abandon the operation; first event after release needs a full debounce interval.
REQ-026 After reset release, no press event SHALL be generated for buttons already held.

Configuration
REQ-027 Macro HALT_CTRL_BRK_EN defined: ports addr (in, 16), brk_addr (in, 16), brk_arm (in, 1) added; in RUN, sync=1 with brk_arm=1 and addr==brk_addr -> HALT with latch_s_n pulse.
REQ-028 Macro HALT_CTRL_BRK_EN undefined: those ports and compare logic absent; RUN leaves only on halt event.

Verification
REQ-029 Reset, no buttons -> state=00, rdy=0, latch_s_n=latch_r_n=1, step_count=0 for 200 cycles.
REQ-030 DEBOUNCE_CYCLES=16; btn_run_n low 10 cycles with bounce -> no transition; held low 40 cycles -> RUN, rdy=1, one latch_r_n pulse.
REQ-031 From HALT, step press; sync 1,0,0,1 -> STEP_A, STEP_B, HALT; rdy low after 2nd sync high; step_count=1; one latch_s_n pulse.
REQ-032 RUN, run and halt pressed same cycle -> HALT, single latch_s_n pulse; 256 completed steps -> step_count=0.
REQ-033 Assert rst_n=0 in STEP_B -> state=00, rdy=0 immediately with no clock edge; step_count=0.
REQ-034 With HALT_CTRL_BRK_EN: brk_addr=16'hC000, brk_arm=1, RUN, sync=1 with addr=16'hC000 -> HALT next edge; brk_arm=0 -> stays RUN.
